// File: rtl/gemm_seq_core.sv
// gemm_seq_core: sequential GEMM. o[j] = a[j] + sum_k i[k]*w[j][k],
// evaluated LANES rows per cycle over PASSES = BLOCK_OUT/LANES cycles.
// The operands are registered when the handshake is accepted. The result
// is held in DONE until the consumer takes it.

// One output row: a signed dot product plus the accumulator seed. All
// arithmetic wraps modulo 2^ACC_WIDTH.
module gemm_lane #(
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int BLOCK_IN  = 16
) (
    input  logic [INP_WIDTH*BLOCK_IN-1:0] i_vec,
    input  logic [WGT_WIDTH*BLOCK_IN-1:0] w_row,
    input  logic [ACC_WIDTH-1:0]          a_val,
    output logic [ACC_WIDTH-1:0]          o_val
);
    localparam int PW = INP_WIDTH + WGT_WIDTH;

    logic signed [PW-1:0] ext_i [BLOCK_IN];
    logic signed [PW-1:0] ext_w [BLOCK_IN];
    logic signed [PW-1:0] prod  [BLOCK_IN];
    logic [ACC_WIDTH-1:0] sum;

    // Both operands are sign-extended to the full product width, so the
    // PW-bit product is exact.
    for (genvar k = 0; k < BLOCK_IN; k++) begin : g_mul
        assign ext_i[k] = PW'($signed(i_vec[k*INP_WIDTH +: INP_WIDTH]));
        assign ext_w[k] = PW'($signed(w_row[k*WGT_WIDTH +: WGT_WIDTH]));
        assign prod[k]  = ext_i[k] * ext_w[k];
    end

    // Reduction tree as a chain. Each product is sign-extended (or
    // truncated) to ACC_WIDTH.
    always_comb begin
        sum = a_val;
        for (int k = 0; k < BLOCK_IN; k++) begin
            sum = sum + ACC_WIDTH'(prod[k]);
        end
    end

    assign o_val = sum;
endmodule

module gemm_seq_core #(
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int BLOCK_IN  = 16,
    parameter int BLOCK_OUT = 16,
    parameter int LANES     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           acc_clr,
    input  logic [INP_WIDTH*BLOCK_IN-1:0]  i_tensor,
    input  logic [WGT_WIDTH*BLOCK_OUT*BLOCK_IN-1:0] w_tensor,
    input  logic [ACC_WIDTH*BLOCK_OUT-1:0] a_tensor,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH*BLOCK_OUT-1:0] o_tensor,
    output logic                           busy
);
    localparam int PASSES = BLOCK_OUT / LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int ROW_W  = (BLOCK_OUT > 1) ? $clog2(BLOCK_OUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PASSES - 1);

    if (LANES < 1 || (BLOCK_OUT % LANES) != 0) begin : g_lanes_check
        $error("gemm_seq_core: LANES (%0d) must divide BLOCK_OUT (%0d)", LANES, BLOCK_OUT);
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [INP_WIDTH*BLOCK_IN-1:0]                 i_reg;
    logic [BLOCK_OUT-1:0][WGT_WIDTH*BLOCK_IN-1:0]  w_reg;
    logic [BLOCK_OUT-1:0][ACC_WIDTH-1:0]           a_reg;
    logic [BLOCK_OUT-1:0][ACC_WIDTH-1:0]           o_reg;

    logic [LANES-1:0][ROW_W-1:0]     row;
    logic [LANES-1:0][ACC_WIDTH-1:0] lane_o;

    // Lane l handles row cnt*LANES + l in the current pass. Row indices
    // are always below BLOCK_OUT, so the ROW_W-bit wrap is harmless.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign row[l] = ROW_W'(cnt) * ROW_W'(LANES) + ROW_W'(l);

        gemm_lane #(
            .INP_WIDTH(INP_WIDTH),
            .WGT_WIDTH(WGT_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .BLOCK_IN (BLOCK_IN)
        ) u_lane (
            .i_vec(i_reg),
            .w_row(w_reg[row[l]]),
            .a_val(a_reg[row[l]]),
            .o_val(lane_o[l])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = CALC;
            CALC:    if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state alone, so reset forces
    // them immediately.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: capture operands on acceptance, then write LANES rows per
    // pass. Rows not yet written keep their previous contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_reg <= '0;
            w_reg <= '0;
            a_reg <= '0;
            o_reg <= '0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            i_reg <= i_tensor;
            w_reg <= w_tensor;
            a_reg <= acc_clr ? '0 : a_tensor;
            cnt   <= '0;
        end else if (state == CALC) begin
            for (int l = 0; l < LANES; l++) begin
                o_reg[row[l]] <= lane_o[l];
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tensor = o_reg;
endmodule
